riscv_fetch_unit: RTL and testbench
===================================

Name: riscv_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation core.
- Replaces the simple free-running PC and combinational instruction path with three pieces:
  - PC generation;
  - a valid/ready request interface to instruction memory with variable latency;
  - a prefetch FIFO feeding the decoder through a valid/ready handshake.
- Accepts redirects (jump/branch) from the control unit and squashes stale fetches.

Parameters:
XLEN, 32, width of PC and fetch address
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  XLEN  fetch address (word aligned)
imem_rsp_valid  in  1  response data valid (exactly one per accepted request)
imem_rsp_data  in  32  fetched instruction
redirect_valid  in  1  control-unit jump/branch redirect
redirect_pc  in  XLEN  redirect target
inst_valid  out  1  instruction available to decoder
inst_ready  in  1  decoder consumes instruction
inst_data  out  32  instruction at FIFO head
inst_pc  out  XLEN  PC of inst_data
fetch_pc  out  XLEN  next address to be requested
occupancy  out  clog2(FIFO_DEPTH)+1  valid FIFO entries

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc=RESET_VECTOR, FIFO empty, occupancy=0.
  - inst_valid=0, imem_req_valid=0, state=REQ.
  - inst_data/inst_pc=0.
- Reset mid-transaction: any outstanding response arriving after reset deasserts is ignored only if it arrives in the first cycle after release; the memory side must be reset together with this block.
- FSM states:
  - REQ: imem_req_valid=1 when occupancy < FIFO_DEPTH, with imem_addr=fetch_pc.
    - On req_valid & req_ready: fetch_pc <= fetch_pc+4 (wraps modulo 2^XLEN), state -> WAIT.
  - WAIT: req_valid=0. On imem_rsp_valid: push {imem_rsp_data, address of the request} into FIFO, state -> REQ.
  - DISCARD: req_valid=0. On imem_rsp_valid: drop data, state -> REQ.
- One outstanding request maximum. A slot is reserved at request acceptance, so a push never overflows.
- FIFO:
  - First-word-fall-through; inst_valid = (occupancy != 0); inst_data/inst_pc = head entry.
  - Pop on inst_valid & inst_ready. Push and pop in the same cycle: occupancy unchanged.
  - Full: no request issued. Empty: inst_valid=0; inst_ready ignored.
- Latency (no bypass): request accepted in cycle N, response in cycle N+k, inst_valid=1 in cycle N+k+1.
- Redirect (highest priority):
  - Flush FIFO (occupancy <= 0, inst_valid=0 next cycle); any same-cycle pop is ignored.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Next state:
    - REQ without handshake -> REQ.
    - REQ with handshake in the same cycle -> DISCARD.
    - WAIT without rsp_valid -> DISCARD.
    - WAIT with rsp_valid in the same cycle -> REQ (response dropped).
    - DISCARD -> DISCARD; a same-cycle rsp_valid moves to REQ instead.
  - Back-to-back redirects: the last one wins.
- imem_addr is always word aligned. PC wrap from 2^XLEN-4 to 0 is legal and silent.

Optional Feature:
- FETCH_BYPASS_EN defined: when the FIFO is empty and a valid, non-discarded response arrives in WAIT, it drives inst_valid/inst_data/inst_pc combinationally in the same cycle.
  - If inst_ready=1, the FIFO is not written.
  - Otherwise it is pushed normally.
  - Latency becomes N+k.
  - A redirect in the same cycle suppresses the bypass.
- Undefined: no combinational path from imem_rsp_* to inst_*; latency N+k+1.

Test Plan:
- Reset release, memory always ready, 1-cycle response, inst_ready=1 -> addresses 0x0,0x4,0x8 requested; inst_pc sequence 0x0,0x4,0x8; inst_valid first high 3 cycles after release.
- inst_ready=0 with FIFO_DEPTH=4 -> exactly 4 requests issued (0x0..0xC), occupancy=4, imem_req_valid stays 0 until the first pop; then one request at 0x10.
- Redirect to 0x103 while in WAIT, response 3 cycles later -> that response dropped, FIFO flushed, next imem_addr=0x100, first inst_pc after redirect=0x100.
- Redirect in the same cycle as rsp_valid -> response dropped, next request at the redirect target the following cycle, occupancy=0.
- Redirect to 0xFFFF_FFFC (XLEN=32) -> requests 0xFFFF_FFFC then 0x0000_0000.
- FETCH_BYPASS_EN defined, FIFO empty, response with inst_ready=1 -> inst_valid high in the response cycle with matching inst_data; occupancy stays 0.

Source files
------------

// File: rtl/riscv_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response and decoder handshake.
// The fetch unit drives through the master modport; the memory/decoder side is the slave.
interface riscv_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: PC gen, one-outstanding imem requests, FWFT prefetch FIFO.
// Define FETCH_BYPASS_EN to forward a response straight to the decoder when the FIFO is empty.
module riscv_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  riscv_fetch_unit_if.master          bus,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic [XLEN-1:0]             fetch_pc,
  output logic [$clog2(FIFO_DEPTH):0] occupancy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DISCARD
  } state_t;

  typedef struct packed {
    logic [31:0]     data;
    logic [XLEN-1:0] pc;
  } fq_t;

  state_t          state_q;
  state_t          state_d;
  logic            run_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] req_pc_q;
  fq_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   wr_q;
  logic [CW-1:0]   cnt_q;

  logic            full;
  logic            empty;
  logic            flush;
  logic            hs;
  logic            rsp;
  logic            push;
  logic            pop;
  logic            byp;
  fq_t             head;
  fq_t             rsp_e;
  logic            unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign empty = cnt_q == '0;
  assign flush = redirect_valid;
  assign rsp   = bus.imem_rsp_valid;
  assign head  = mem_q[rd_q];
  assign rsp_e = '{data: bus.imem_rsp_data, pc: req_pc_q};

  // run_q holds off the first request for one cycle after reset release
  assign bus.imem_req_valid = run_q && (state_q == S_REQ) && !full;
  assign bus.imem_addr      = pc_q;
  assign hs = bus.imem_req_valid && bus.imem_req_ready;

`ifdef FETCH_BYPASS_EN
  assign byp = (state_q == S_WAIT) && rsp && !flush && empty;
`else
  assign byp = 1'b0;
`endif

  assign bus.inst_valid = !empty || byp;
  assign bus.inst_data  = !empty ? head.data :
                          byp    ? rsp_e.data : '0;
  assign bus.inst_pc    = !empty ? head.pc :
                          byp    ? rsp_e.pc : '0;

  assign pop  = !empty && bus.inst_ready && !flush;
  assign push = (state_q == S_WAIT) && rsp && !flush &&
                !(byp && bus.inst_ready);

  assign fetch_pc  = pc_q;
  assign occupancy = cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (hs) state_d = flush ? S_DISCARD : S_WAIT;
      end
      S_WAIT: begin
        if (rsp)        state_d = S_REQ;
        else if (flush) state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (rsp) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (flush)   pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    else if (hs) pc_d = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      run_q    <= 1'b0;
      pc_q     <= {RESET_VECTOR[XLEN-1:2], 2'b00};
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      if (hs) req_pc_q <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= rsp_e;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: directed scenarios plus a
// randomized run against a program-order reference model.
module tb_riscv_fetch_unit;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  riscv_fetch_unit_if #(.XLEN(XLEN)) ifc ();

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] fetch_pc;
  logic [2:0]      occupancy;

  riscv_fetch_unit #(
    .XLEN(XLEN),
    .RESET_VECTOR(32'h0000_0000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc),
    .occupancy(occupancy)
  );

  int checks = 0;
  int errors = 0;

  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        t_hs;
  logic        t_rsp;
  logic [31:0] t_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder plus one clock step; returns at negedge+1.
  task automatic tick();
    t_hs   = ifc.imem_req_valid && ifc.imem_req_ready;
    t_rsp  = ifc.imem_rsp_valid;
    t_addr = ifc.imem_addr;
    @(posedge clk);
    if (t_rsp) mem_pend = 1'b0;
    if (t_hs) begin
      mem_pend = 1'b1;
      mem_addr = t_addr;
      mem_cnt  = $urandom_range(lat_max, lat_min);
    end else if (mem_pend) begin
      mem_cnt--;
    end
    @(negedge clk);
    ifc.imem_rsp_valid = mem_pend && (mem_cnt == 1);
    ifc.imem_rsp_data  = ifc.imem_rsp_valid ? memf(mem_addr) : $urandom;
    #1;
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    ifc.imem_req_ready = 1'b0;
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = '0;
    ifc.inst_ready     = 1'b0;
    mem_pend           = 1'b0;
    mem_cnt            = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b0;
    repeat (8) begin
      #1;
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (fetch_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_fetch_pc: got %h want 00000000", fetch_pc);
    end
    checks++;
    if (occupancy !== 3'd0) begin
      errors++;
      $display("FAIL reset_occupancy: got %0d want 0", occupancy);
    end
    checks++;
    if (ifc.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_inst_valid: got %b want 0", ifc.inst_valid);
    end
    checks++;
    if (ifc.imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_req_valid: got %b want 0", ifc.imem_req_valid);
    end
    checks++;
    if (ifc.inst_data !== 32'h0 || ifc.inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_inst_bus: got %h/%h want 0/0",
               ifc.inst_data, ifc.inst_pc);
    end
  endtask

  task automatic test_latency();
    int          first;
    logic [31:0] pcs[$];
    logic [31:0] dat[$];
    logic [31:0] req[$];
    do_reset();
    lat_min = 1;
    lat_max = 1;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    first = -1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      #1;
      if (ifc.inst_valid && first < 0) first = cyc;
      if (ifc.inst_valid) begin
        pcs.push_back(ifc.inst_pc);
        dat.push_back(ifc.inst_data);
      end
      tick();
      if (t_hs) req.push_back(t_addr);
    end
    checks++;
    if (first != 3) begin
      errors++;
      $display("FAIL latency_first_valid: got cycle %0d want 3", first);
    end
    checks++;
    if (pcs.size() < 3 || req.size() < 3) begin
      errors++;
      $display("FAIL latency_count: got %0d pcs %0d reqs want >=3",
               pcs.size(), req.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (pcs[i] !== 32'(4 * i) || dat[i] !== memf(32'(4 * i)) ||
            req[i] !== 32'(4 * i)) begin
          errors++;
          $display("FAIL latency_seq[%0d]: got pc %h data %h req %h want %h",
                   i, pcs[i], dat[i], req[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] req[$];
    logic        got;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b0;
    repeat (20) begin
      #1;
      tick();
      if (t_hs) req.push_back(t_addr);
    end
    checks++;
    if (req.size() != DEPTH) begin
      errors++;
      $display("FAIL fill_req_count: got %0d want %0d", req.size(), DEPTH);
    end
    foreach (req[i]) begin
      checks++;
      if (req[i] !== 32'(4 * i)) begin
        errors++;
        $display("FAIL fill_req_addr[%0d]: got %h want %h",
                 i, req[i], 32'(4 * i));
      end
    end
    checks++;
    if (occupancy !== 3'd4 || ifc.imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got occ %0d req_valid %b want 4/0",
               occupancy, ifc.imem_req_valid);
    end
    ifc.inst_ready = 1'b1;
    #1;
    checks++;
    if (ifc.inst_pc !== 32'h0) begin
      errors++;
      $display("FAIL fill_head_pc: got %h want 00000000", ifc.inst_pc);
    end
    tick();
    ifc.inst_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      #1;
      tick();
      got = t_hs;
    end
    checks++;
    if (!got || t_addr !== 32'h10) begin
      errors++;
      $display("FAIL fill_refill: got hs %b addr %h want 1/00000010",
               got, t_addr);
    end
  endtask

  task automatic test_redirect_wait();
    logic got;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      tick();
      got = t_hs;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    #1;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (occupancy !== 3'd0) begin
      errors++;
      $display("FAIL rdw_flush: got occ %0d want 0", occupancy);
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      tick();
      got = t_hs;
    end
    checks++;
    if (!got || t_addr !== 32'h100) begin
      errors++;
      $display("FAIL rdw_next_addr: got hs %b addr %h want 1/00000100",
               got, t_addr);
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      got = ifc.inst_valid;
      if (!got) tick();
    end
    checks++;
    if (!got || ifc.inst_pc !== 32'h100 ||
        ifc.inst_data !== memf(32'h100)) begin
      errors++;
      $display("FAIL rdw_first_inst: got v %b pc %h data %h want pc 00000100",
               got, ifc.inst_pc, ifc.inst_data);
    end
  endtask

  task automatic test_redirect_rsp();
    logic got;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      tick();
      got = t_hs;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (occupancy !== 3'd0 || ifc.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdr_drop: got occ %0d inst_valid %b want 0/0",
               occupancy, ifc.inst_valid);
    end
    checks++;
    if (ifc.imem_req_valid !== 1'b1 || ifc.imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL rdr_next_req: got v %b addr %h want 1/00000200",
               ifc.imem_req_valid, ifc.imem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] req[$];
    do_reset();
    lat_min = 1;
    lat_max = 2;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    repeat (3) begin
      #1;
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    #1;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && req.size() < 2; i++) begin
      #1;
      tick();
      if (t_hs) req.push_back(t_addr);
    end
    checks++;
    if (req.size() != 2 || req[0] !== 32'hFFFF_FFFC || req[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_reqs: got %0d reqs first %h want FFFFFFFC then 0",
               req.size(), (req.size() > 0) ? req[0] : 32'hx);
    end
  endtask

  task automatic test_bypass();
    logic got;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    ifc.imem_req_ready = 1'b1;
    ifc.inst_ready     = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #1;
      tick();
      got = t_hs;
    end
    #1;
`ifdef FETCH_BYPASS_EN
    checks++;
    if (ifc.inst_valid !== 1'b1 || ifc.inst_pc !== 32'h0 ||
        ifc.inst_data !== memf(32'h0)) begin
      errors++;
      $display("FAIL bypass_same_cycle: got v %b pc %h data %h want 1/0/%h",
               ifc.inst_valid, ifc.inst_pc, ifc.inst_data, memf(32'h0));
    end
    tick();
    checks++;
    if (occupancy !== 3'd0) begin
      errors++;
      $display("FAIL bypass_no_push: got occ %0d want 0", occupancy);
    end
`else
    checks++;
    if (ifc.inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL nobypass_rsp_cycle: got inst_valid %b want 0",
               ifc.inst_valid);
    end
    ifc.inst_ready = 1'b0;
    tick();
    checks++;
    if (occupancy !== 3'd1 || ifc.inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL nobypass_push: got occ %0d v %b want 1/1",
               occupancy, ifc.inst_valid);
    end
`endif
  endtask

  // Reference: instructions leave in program order from the last redirect
  // target; requests walk the same order; responses for requests that were
  // in flight across a redirect never reach the decoder.
  task automatic test_random();
    int          e_occ;
    logic [31:0] e_fetch;
    logic [31:0] e_head;
    logic        e_outst;
    logic        e_stale;
    logic        e_run;
    logic        e_req;
    logic        e_byp;
    logic        e_ival;
    logic        rsp;
    logic        hs;
    logic        kept;
    logic        pop;
    int          consumed;
    int          rdy_bias;
    do_reset();
    lat_min  = 1;
    lat_max  = 4;
    e_occ    = 0;
    e_fetch  = 32'h0;
    e_head   = 32'h0;
    e_outst  = 1'b0;
    e_stale  = 1'b0;
    e_run    = 1'b0;
    consumed = 0;
    rdy_bias = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) rdy_bias = $urandom_range(3, 0);
      ifc.imem_req_ready = $urandom_range(3, 0) != 0;
      ifc.inst_ready     = $urandom_range(3, 0) < 3 - rdy_bias + 1;
      redirect_valid     = $urandom_range(15, 0) == 0;
      redirect_pc        = $urandom_range(1, 0) ? $urandom :
                           32'hFFFF_FFF0 + $urandom_range(15, 0);
      #1;
      rsp   = ifc.imem_rsp_valid;
      e_req = e_run && !e_outst && (e_occ < DEPTH);
`ifdef FETCH_BYPASS_EN
      e_byp = rsp && e_outst && !e_stale && !redirect_valid && (e_occ == 0);
`else
      e_byp = 1'b0;
`endif
      e_ival = (e_occ != 0) || e_byp;
      checks++;
      if (ifc.inst_valid !== e_ival) begin
        errors++;
        $display("FAIL rnd_inst_valid @%0d: got %b want %b",
                 cyc, ifc.inst_valid, e_ival);
      end
      if (e_ival) begin
        checks++;
        if (ifc.inst_pc !== e_head || ifc.inst_data !== memf(e_head)) begin
          errors++;
          $display("FAIL rnd_inst @%0d: got pc %h data %h want %h %h",
                   cyc, ifc.inst_pc, ifc.inst_data, e_head, memf(e_head));
        end
      end
      checks++;
      if (occupancy !== 3'(e_occ)) begin
        errors++;
        $display("FAIL rnd_occupancy @%0d: got %0d want %0d",
                 cyc, occupancy, e_occ);
      end
      checks++;
      if (ifc.imem_req_valid !== e_req) begin
        errors++;
        $display("FAIL rnd_req_valid @%0d: got %b want %b",
                 cyc, ifc.imem_req_valid, e_req);
      end
      checks++;
      if (fetch_pc !== e_fetch) begin
        errors++;
        $display("FAIL rnd_fetch_pc @%0d: got %h want %h",
                 cyc, fetch_pc, e_fetch);
      end
      if (e_req) begin
        checks++;
        if (ifc.imem_addr !== e_fetch) begin
          errors++;
          $display("FAIL rnd_imem_addr @%0d: got %h want %h",
                   cyc, ifc.imem_addr, e_fetch);
        end
      end
      hs   = e_req && ifc.imem_req_ready;
      kept = rsp && e_outst && !e_stale && !redirect_valid;
      pop  = e_ival && ifc.inst_ready && !redirect_valid;
      if (redirect_valid) begin
        e_occ   = 0;
        e_fetch = {redirect_pc[31:2], 2'b00};
        e_head  = {redirect_pc[31:2], 2'b00};
      end else begin
        if (kept && !(e_byp && ifc.inst_ready)) e_occ++;
        if (pop && !e_byp) e_occ--;
        if (pop) begin
          e_head = e_head + 32'd4;
          consumed++;
        end
        if (hs) e_fetch = e_fetch + 32'd4;
      end
      if (rsp) begin
        e_outst = 1'b0;
        e_stale = 1'b0;
      end
      if (hs) begin
        e_outst = 1'b1;
        e_stale = redirect_valid;
      end else if (redirect_valid && e_outst && !rsp) begin
        e_stale = 1'b1;
      end
      e_run = 1'b1;
      tick();
    end
    redirect_valid = 1'b0;
    checks++;
    if (consumed < 100) begin
      errors++;
      $display("FAIL rnd_progress: got %0d instructions want >=100", consumed);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
